// File: rtl/lab4_net_router_nport.sv
// N-port input-queued router: one FIFO per input, one round-robin IDLE/LOCKED arbiter per output.
// Define LAB4_NET_ROUTER_NPORT_BYPASS_EN to let an empty queue forward its incoming message same-cycle.
module lab4_net_router_nport #(
  parameter int unsigned p_num_ports     = 3,
  parameter int unsigned p_queue_depth   = 2,
  parameter int unsigned p_payload_nbits = 32,
  parameter int unsigned p_dest_nbits    = 2
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [p_num_ports-1:0]                                in_val,
  output logic [p_num_ports-1:0]                                in_rdy,
  input  logic [p_num_ports*(p_dest_nbits+p_payload_nbits)-1:0] in_msg,
  output logic [p_num_ports-1:0]                                out_val,
  input  logic [p_num_ports-1:0]                                out_rdy,
  output logic [p_num_ports*(p_dest_nbits+p_payload_nbits)-1:0] out_msg
);

  localparam int unsigned N    = p_num_ports;
  localparam int unsigned D    = p_queue_depth;
  localparam int unsigned M    = p_dest_nbits + p_payload_nbits;
  localparam int unsigned PtrW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned CntW = $clog2(D + 1);
  localparam int unsigned IdxW = $clog2(N);

  typedef enum logic {StIdle, StLocked} state_e;

  // Input queues
  logic [M-1:0]            mem_q    [N][D];
  logic [PtrW-1:0]         rd_ptr_q [N];
  logic [PtrW-1:0]         wr_ptr_q [N];
  logic [CntW-1:0]         cnt_q    [N];
  logic [N-1:0]            full, empty, enq, deq, push, pop, head_val;
  logic [M-1:0]            head_msg [N];
  logic [p_dest_nbits-1:0] dest     [N];
  logic [IdxW-1:0]         target   [N];

  // Output arbiters
  state_e          state_q [N];
  state_e          state_d [N];
  logic [IdxW-1:0] gnt_q   [N];
  logic [IdxW-1:0] gnt_d   [N];
  logic [IdxW-1:0] ptr_q   [N];
  logic [IdxW-1:0] ptr_d   [N];
  logic [IdxW-1:0] sel     [N];
  logic [N-1:0]    sel_val;
  logic [IdxW-1:0] idx;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      full[i]   = (cnt_q[i] == CntW'(D));
      empty[i]  = (cnt_q[i] == '0);
      in_rdy[i] = !full[i] || reset;
      enq[i]    = in_val[i] && !full[i] && !reset;
`ifdef LAB4_NET_ROUTER_NPORT_BYPASS_EN
      head_val[i] = !empty[i] || enq[i];
      head_msg[i] = empty[i] ? in_msg[i*M +: M] : mem_q[i][rd_ptr_q[i]];
`else
      head_val[i] = !empty[i];
      head_msg[i] = mem_q[i][rd_ptr_q[i]];
`endif
      dest[i]   = head_msg[i][M-1 -: p_dest_nbits];
      // Out-of-range destinations fold onto the last output
      target[i] = (32'(dest[i]) < N) ? IdxW'(dest[i]) : IdxW'(N - 1);
    end
  end

  always_comb begin
    deq     = '0;
    out_val = '0;
    out_msg = '0;
    sel_val = '0;
    idx     = '0;
    for (int o = 0; o < N; o++) begin
      state_d[o] = state_q[o];
      gnt_d[o]   = gnt_q[o];
      ptr_d[o]   = ptr_q[o];
      sel[o]     = '0;
      if (state_q[o] == StLocked) begin
        sel[o]     = gnt_q[o];
        sel_val[o] = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          idx = IdxW'((32'(ptr_q[o]) + k) % N);
          if (!sel_val[o] && head_val[idx] && target[idx] == IdxW'(o)) begin
            sel_val[o] = 1'b1;
            sel[o]     = idx;
          end
        end
      end
      if (sel_val[o] && !reset) begin
        out_val[o]         = 1'b1;
        out_msg[o*M +: M]  = head_msg[sel[o]];
        if (out_rdy[o]) begin
          deq[sel[o]] = 1'b1;
          ptr_d[o]    = (sel[o] == IdxW'(N - 1)) ? '0 : sel[o] + 1'b1;
          state_d[o]  = StIdle;
        end else if (state_q[o] == StIdle) begin
          gnt_d[o]   = sel[o];
          state_d[o] = StLocked;
        end
      end
    end
  end

  // A bypassed message (enqueued and dequeued while empty) never touches the storage
  always_comb begin
    for (int i = 0; i < N; i++) begin
      push[i] = enq[i] && !(empty[i] && deq[i]);
      pop[i]  = deq[i] && !(empty[i] && enq[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        state_q[i]  <= StIdle;
        gnt_q[i]    <= '0;
        ptr_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i]) begin
          wr_ptr_q[i] <= (wr_ptr_q[i] == PtrW'(D - 1)) ? '0 : wr_ptr_q[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= (rd_ptr_q[i] == PtrW'(D - 1)) ? '0 : rd_ptr_q[i] + 1'b1;
        end
        if (push[i] && !pop[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (pop[i] && !push[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
        state_q[i] <= state_d[i];
        gnt_q[i]   <= gnt_d[i];
        ptr_q[i]   <= ptr_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_msg[i*M +: M];
      end
    end
  end

endmodule

// File: tb/tb_lab4_net_router_nport.sv
// Scoreboard bench for lab4_net_router_nport (N=3, depth 2, 32-bit payload, 2-bit dest).
module tb_lab4_net_router_nport;

  localparam int N = 3;
  localparam int M = 34;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_val, in_rdy, out_val, out_rdy;
  logic [N*M-1:0] in_msg, out_msg;

  always #5 clk = ~clk;

  lab4_net_router_nport dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected messages per (output, input) pair; per-input order must be preserved
  logic [M-1:0] exp_q [N*N][$];
  logic [M-1:0] out1_log [$];
  logic [N-1:0] hold_q = '0;
  logic [M-1:0] hold_msg [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [M-1:0] mk(input logic [1:0] d, input logic [31:0] pl);
    return {d, pl};
  endfunction

  function automatic int route(input logic [M-1:0] m);
    int d;
    d = int'(m[M-1 -: 2]);
    return (d < N) ? d : N - 1;
  endfunction

  // Monitor: record accepted inputs, then score outputs that transfer at the coming edge
  always @(negedge clk) begin
    logic [M-1:0] m;
    logic         found;
    if (reset) begin
      for (int k = 0; k < N * N; k++) exp_q[k].delete();
      hold_q = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_val[i] && in_rdy[i]) begin
          m = in_msg[i*M +: M];
          exp_q[route(m)*N + i].push_back(m);
        end
      end
      for (int o = 0; o < N; o++) begin
        m = out_msg[o*M +: M];
        if (hold_q[o]) begin
          check("hold_val", 64'(out_val[o]), 64'd1);
          check("hold_msg", 64'(m), 64'(hold_msg[o]));
        end
        if (!out_val[o]) begin
          check("idle_msg", 64'(m), 64'd0);
        end else if (out_rdy[o]) begin
          found = 1'b0;
          for (int i = 0; i < N; i++) begin
            if (!found && exp_q[o*N + i].size() > 0 && exp_q[o*N + i][0] == m) begin
              void'(exp_q[o*N + i].pop_front());
              found = 1'b1;
            end
          end
          n_checks++;
          if (!found) begin
            n_fail++;
            $display("FAIL scoreboard out%0d: got %h, expected a queued message", o, m);
          end
          if (o == 1) out1_log.push_back(m);
        end
        hold_q[o]   = out_val[o] && !out_rdy[o];
        hold_msg[o] = m;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int p, input logic [1:0] d, input logic [31:0] pl);
    in_val[p]         = 1'b1;
    in_msg[p*M +: M]  = mk(d, pl);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    in_val  = '0;
    out_rdy = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    logic [31:0] rr_exp [6];
    rr_exp = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hB2};
    reset   = 1'b1;
    in_val  = '0;
    in_msg  = '0;
    out_rdy = '0;
    tick();
    tick();
    check("rst_in_rdy", 64'(in_rdy), 64'h7);
    check("rst_out_val", 64'(out_val), 64'h0);
    check("rst_out_msg", 64'(out_msg), 64'h0);
    reset = 1'b0;

    // Single message to output 2
    out_rdy = 3'b111;
    set_in(0, 2'd2, 32'hDEAD0001);
`ifdef LAB4_NET_ROUTER_NPORT_BYPASS_EN
    #1;
    check("byp_val", 64'(out_val), 64'h4);
    check("byp_msg", 64'(out_msg[2*M +: M]), 64'(mk(2'd2, 32'hDEAD0001)));
`endif
    tick();
    in_val = '0;
`ifndef LAB4_NET_ROUTER_NPORT_BYPASS_EN
    check("lat_val", 64'(out_val), 64'h4);
    check("lat_msg", 64'(out_msg[2*M +: M]), 64'(mk(2'd2, 32'hDEAD0001)));
`endif
    tick();
    tick();

    // Round-robin on output 1
    do_reset();
    out_rdy = 3'b010;
    out1_log.delete();
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < N; p++) set_in(p, 2'd1, 32'hA0 + 32'(b * 16 + p));
      tick();
    end
    in_val = '0;
    repeat (8) tick();
    check("rr_count", 64'(out1_log.size()), 64'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < out1_log.size()) check("rr_order", 64'(out1_log[k][31:0]), 64'(rr_exp[k]));
    end

    // Locked output holds its message under backpressure
    do_reset();
    set_in(1, 2'd0, 32'h11);
    set_in(2, 2'd0, 32'h22);
    tick();
    in_val = '0;
    for (int c = 0; c < 5; c++) begin
      check("lock_val", 64'(out_val[0]), 64'd1);
      check("lock_msg", 64'(out_msg[0 +: M]), 64'(mk(2'd0, 32'h11)));
      tick();
    end
    out_rdy = 3'b001;
    tick();
    check("lock_next_val", 64'(out_val[0]), 64'd1);
    check("lock_next_msg", 64'(out_msg[0 +: M]), 64'(mk(2'd0, 32'h22)));
    tick();
    tick();

    // Queue full and ordering
    do_reset();
    out1_log.delete();
    set_in(0, 2'd1, 32'h301);
    tick();
    check("q_rdy_1", 64'(in_rdy[0]), 64'd1);
    set_in(0, 2'd1, 32'h302);
    tick();
    check("q_full", 64'(in_rdy[0]), 64'd0);
    set_in(0, 2'd1, 32'h303);
    repeat (3) begin
      tick();
      check("q_stay_full", 64'(in_rdy[0]), 64'd0);
    end
    out_rdy = 3'b010;
    #1;
    check("q_rdy_indep_deq", 64'(in_rdy[0]), 64'd0);
    tick();
    check("q_rdy_after_deq", 64'(in_rdy[0]), 64'd1);
    tick();
    in_val = '0;
    repeat (4) tick();
    check("q_count", 64'(out1_log.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < out1_log.size()) check("q_order", 64'(out1_log[k][31:0]), 64'(32'h301 + k));
    end

    // Out-of-range dest folds to last output
    do_reset();
    out_rdy = 3'b111;
    set_in(0, 2'd3, 32'h7);
`ifdef LAB4_NET_ROUTER_NPORT_BYPASS_EN
    #1;
    check("fold_val", 64'(out_val), 64'h4);
    check("fold_msg", 64'(out_msg[2*M +: M]), 64'(mk(2'd3, 32'h7)));
`endif
    tick();
    in_val = '0;
`ifndef LAB4_NET_ROUTER_NPORT_BYPASS_EN
    check("fold_val", 64'(out_val), 64'h4);
    check("fold_msg", 64'(out_msg[2*M +: M]), 64'(mk(2'd3, 32'h7)));
`endif
    tick();
    tick();

    // Reset while locked discards state and restores priority pointer
    do_reset();
    out_rdy = 3'b111;
    set_in(0, 2'd0, 32'h401);
    tick();
    in_val = '0;
    tick();
    tick();
    out_rdy = 3'b000;
    set_in(2, 2'd0, 32'h402);
    set_in(1, 2'd1, 32'h403);
    tick();
    in_val = '0;
    set_in(2, 2'd0, 32'h404);
    tick();
    in_val = '0;
    tick();
    check("pre_rst_lock", 64'(out_msg[0 +: M]), 64'(mk(2'd0, 32'h402)));
    reset = 1'b1;
    #1;
    check("in_rst_val", 64'(out_val), 64'h0);
    check("in_rst_rdy", 64'(in_rdy), 64'h7);
    tick();
    reset = 1'b0;
    check("post_rst_val", 64'(out_val), 64'h0);
    check("post_rst_rdy", 64'(in_rdy), 64'h7);
    out_rdy = 3'b001;
    set_in(0, 2'd0, 32'h405);
    set_in(2, 2'd0, 32'h406);
`ifdef LAB4_NET_ROUTER_NPORT_BYPASS_EN
    #1;
    check("rst_ptr_byp", 64'(out_msg[0 +: M]), 64'(mk(2'd0, 32'h405)));
`endif
    tick();
    in_val = '0;
`ifndef LAB4_NET_ROUTER_NPORT_BYPASS_EN
    check("rst_ptr", 64'(out_msg[0 +: M]), 64'(mk(2'd0, 32'h405)));
`endif

    // Drain everything still expected
    out_rdy = 3'b111;
    total   = 1;
    for (int c = 0; c < 50 && total != 0; c++) begin
      tick();
      total = 0;
      for (int k = 0; k < N * N; k++) total += exp_q[k].size();
    end
    check("drain", 64'(total), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lab4_net_router_nport.md
LAB4_NET_ROUTER_NPORT -- requirements
Module: lab4_net_router_nport

Interface
REQ-001 SHALL have parameter p_num_ports, default 3, number of input/output port pairs (legal 2..8).
REQ-002 SHALL have parameter p_queue_depth, default 2, entries per input queue (legal 1..16).
REQ-003 SHALL have parameter p_payload_nbits, default 32, payload width.
REQ-004 SHALL have parameter p_dest_nbits, default 2, header dest width; must satisfy 2^p_dest_nbits >= p_num_ports.
REQ-005 Message width M = p_dest_nbits + p_payload_nbits, dest in MSBs, payload in LSBs.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 in_val  input  N  per-port enqueue valid.
REQ-009 in_rdy  output  N  per-port enqueue ready.
REQ-010 in_msg  input  N*M  port i occupies bits [i*M +: M].
REQ-011 out_val  output  N  per-port output valid.
REQ-012 out_rdy  input  N  per-port output ready.
REQ-013 out_msg  output  N*M  port o occupies bits [o*M +: M].

Function
REQ-014 Transfer on any val/rdy pair SHALL occur exactly when val && rdy at a rising edge.
REQ-015 Each input SHALL have a FIFO of p_queue_depth entries; in_rdy[i] = !full[i], independent of in_val and of same-cycle dequeue.
REQ-016 Head of input i SHALL request output o = dest when dest < N, else output N-1.
REQ-017 Each output SHALL run a two-state FSM: IDLE, LOCKED.
REQ-018 IDLE: if any requester, grant round-robin starting at priority pointer ptr[o]; out_val[o]=1 and out_msg[o]=granted head in that same cycle.
REQ-019 IDLE with grant and out_rdy[o]=1: head dequeued, ptr[o] <= (g+1) mod N, stay IDLE.
REQ-020 IDLE with grant and out_rdy[o]=0: latch g, go LOCKED; ptr unchanged.
REQ-021 LOCKED: out_val[o]=1, out_msg[o] held from latched input, ignoring other requests; on out_rdy[o]=1 dequeue, ptr[o] <= (g+1) mod N, go IDLE.
REQ-022 out_msg SHALL remain stable while out_val=1 and out_rdy=0.
REQ-023 With no requester, out_val[o]=0 and out_msg[o]=0.
REQ-024 One input head requests only one output, so at most one dequeue per input per cycle.
REQ-025 Minimum latency in_val to out_val = 1 cycle (message visible at head the cycle after enqueue).
REQ-026 Simultaneous enqueue and dequeue on a non-full queue SHALL both succeed; occupancy unchanged.
REQ-027 Queue pointers SHALL wrap modulo p_queue_depth without loss; the FIFO is order-preserving per input.

Reset
REQ-028 While reset=1: all queues empty, in_rdy=all ones, out_val=0, out_msg=0, all FSMs IDLE, all ptr=0.
REQ-029 Reset asserted mid-transfer SHALL discard all queued and locked messages; no transfer occurs on a reset cycle.

Configuration
REQ-030 Macro LAB4_NET_ROUTER_NPORT_BYPASS_EN defined: a message enqueued into an empty queue SHALL be eligible for grant in the same cycle (latency 0 combinational path in_msg->out_msg); it is not stored if dequeued that cycle.
REQ-031 Macro undefined: no combinational in->out path; latency per REQ-025.

Verification
REQ-032 N=3, D=2: port0 sends dest=2 payload 0xDEAD0001, out_rdy=all 1 -> out_val[2]=1 with that msg one cycle later, other outputs idle.
REQ-033 Ports 0,1,2 all send dest=1 every cycle, out_rdy[1]=1 -> grants in order 0,1,2,0,1,2 on output 1.
REQ-034 Port1 sends dest=0 payload 0x11, out_rdy[0]=0 for 5 cycles while port2 also requests 0 -> out_msg[0] stays 0x11 all 5 cycles, then 0x11 accepted, then port2's message follows.
REQ-035 out_rdy=0, port0 sends 3 msgs -> in_rdy[0] drops after 2nd enqueue; third accepted only after first dequeue; order preserved.
REQ-036 N=3, dest=3 payload 0x7 on port0 -> appears on output 2.
REQ-037 Reset asserted while output 0 LOCKED with queues holding messages -> next cycle out_val=0, in_rdy=all 1, ptr=0; with BYPASS_EN, empty-queue message appears on out_msg in its enqueue cycle.
